// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: pipelined carry-select add/sub with valid/ready backpressure.
// Define CSEL_ADD_SAT_EN to clamp the sum to signed max/min on overflow.
module csel_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int BLK       = 4,
  parameter int PIPE_BLKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK   = WIDTH / BLK;
  localparam int STAGES = NBLK / PIPE_BLKS;
  localparam int SW     = BLK * PIPE_BLKS;
  localparam int L      = STAGES - 1;
  genvar k, j;
  generate
    for (k = 0; k < STAGES; k++) begin : g_st
      // Stage k sees only the operand bits it has not yet consumed.
      localparam int UW = WIDTH - k * SW;
      logic [UW-1:0]         w_ua, w_ub;
      logic [(k+1)*SW-1:0]   w_sn;
      logic [SW-1:0]         w_s;
      logic                  w_ci, w_vi, w_nx, w_ld;
      logic                  r_v, r_c;
      logic [(k+1)*SW-1:0]   r_s;
      if (k == 0) begin : g_in
        assign w_ua = a;
        assign w_ub = sub ? ~b : b;
        assign w_ci = sub | cin;
        assign w_vi = in_valid;
        assign w_sn = w_s;
      end else begin : g_mid
        assign w_ua = g_st[k-1].g_up.r_ua;
        assign w_ub = g_st[k-1].g_up.r_ub;
        assign w_ci = g_st[k-1].r_c;
        assign w_vi = g_st[k-1].r_v;
        assign w_sn = {w_s, g_st[k-1].r_s};
      end
      for (j = 0; j < PIPE_BLKS; j++) begin : g_blk
        logic w_bc, w_co;
        if (j == 0) begin : g_rc
          assign w_bc = w_ci;
          assign {w_co, w_s[BLK-1:0]} = {1'b0, w_ua[BLK-1:0]} + {1'b0, w_ub[BLK-1:0]} + {{BLK{1'b0}}, w_bc};
        end else begin : g_cs
          logic [BLK:0] w_r0, w_r1;
          assign w_bc = g_blk[j-1].w_co;
          assign w_r0 = {1'b0, w_ua[j*BLK+:BLK]} + {1'b0, w_ub[j*BLK+:BLK]};
          assign w_r1 = {1'b0, w_ua[j*BLK+:BLK]} + {1'b0, w_ub[j*BLK+:BLK]} + (BLK+1)'(1);
          assign {w_co, w_s[j*BLK+:BLK]} = w_bc ? w_r1 : w_r0;
        end
      end
      assign w_ld = !r_v || w_nx;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_v <= 1'b0;
          r_c <= 1'b0;
          r_s <= '0;
        end else if (w_ld) begin
          r_v <= w_vi;
          r_c <= g_blk[PIPE_BLKS-1].w_co;
          r_s <= w_sn;
        end
      if (k < L) begin : g_up
        logic [UW-SW-1:0] r_ua, r_ub;
        assign w_nx = g_st[k+1].w_ld;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) begin
            r_ua <= '0;
            r_ub <= '0;
          end else if (w_ld) begin
            r_ua <= w_ua[UW-1:SW];
            r_ub <= w_ub[UW-1:SW];
          end
      end else begin : g_last
        logic r_o;
`ifdef CSEL_ADD_SAT_EN
        logic r_am;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) r_am <= 1'b0;
          else if (w_ld) r_am <= w_ua[UW-1];
`endif
        assign w_nx = out_ready;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) r_o <= 1'b0;
          else if (w_ld) r_o <= (w_ua[UW-1] == w_ub[UW-1]) && (w_s[SW-1] != w_ua[UW-1]);
      end
    end
  endgenerate
  assign in_ready  = g_st[0].w_ld;
  assign out_valid = g_st[L].r_v;
  assign cout      = g_st[L].r_c;
  assign ovf       = g_st[L].g_last.r_o;
`ifdef CSEL_ADD_SAT_EN
  assign sum = ovf ? {g_st[L].g_last.r_am, {(WIDTH-1){~g_st[L].g_last.r_am}}} : g_st[L].r_s;
`else
  assign sum = g_st[L].r_s;
`endif
endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb_csel_adder_pipe: directed vectors plus an arithmetic reference model for csel_adder_pipe.
module tb_csel_adder_pipe;
`ifdef CSEL_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid, cout, ovf;
  logic [31:0] a = 0, b = 0, sum;
  int total = 0, passed = 0, n_in = 0, n_out = 0, cyc = 0;
  logic [33:0] exp_q[$];
  logic [31:0] outs[$];
  int ocyc[$];
  logic stall = 0;
  logic [33:0] held;
  logic done;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(32), .BLK(4), .PIPE_BLKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic logic [33:0] model(input logic [31:0] x, y, input logic c, s);
    logic [31:0] yy, r;
    logic [32:0] t;
    logic o;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + 33'(s ? 1'b1 : c);
    o = (x[31] == yy[31]) && (t[31] != x[31]);
    r = t[31:0];
    if (SAT && o) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {o, t[32], r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall = 0;
    end else begin
      cyc++;
      if (stall) chk("stall_hold", {29'd0, out_valid, ovf, cout, sum}, {29'd0, 1'b1, held});
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else chk("model", {30'd0, ovf, cout, sum}, {30'd0, exp_q[0]});
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          outs.push_back(sum);
          ocyc.push_back(cyc);
          n_out++;
        end
      end
      stall = out_valid && !out_ready;
      held = {ovf, cout, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_in++;
      end
    end
  end

  // Called one time unit after a rising edge; returns likewise after the beat is taken.
  task automatic send(input logic [31:0] x, y, input logic c, s);
    int n;
    in_valid = 1; a = x; b = y; cin = c; sub = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("send_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic lit(input string nm, input logic [31:0] x, y, input logic c, s,
                     input logic [31:0] es, input logic ec, eo);
    int n;
    send(x, y, c, s);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_lat"}, 64'(n), 64'd2);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    lit("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 32'h0, 1, 0);
    lit("add_ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1);
    lit("sub_neg", 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0);
    lit("sub_pos", 32'd7, 32'd5, 1, 1, 32'd2, 1, 0);
    lit("sub_ovf", 32'h8000_0000, 32'h1, 0, 1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1);
    lit("add_cin_stage", 32'h0000_FFFF, 32'h0, 1, 0, 32'h0001_0000, 0, 0);
    lit("add_chain", 32'h1234_5678, 32'h0FED_CBA8, 0, 0, 32'h2222_2220, 0, 0);

    outs.delete(); ocyc.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; a = i; b = i; cin = 0; sub = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    for (int n = 0; n < 30 && outs.size() < 10; n++) @(negedge clk);
    #1;
    chk("stream_count", 64'(outs.size()), 64'd10);
    for (int i = 0; i < outs.size() && i < 10; i++) chk("stream_val", 64'(outs[i]), 64'(2 * i));
    if (ocyc.size() >= 10) chk("stream_rate", 64'(ocyc[9] - ocyc[0]), 64'd9);
    @(posedge clk); #1;

    outs.delete();
    out_ready = 0;
    base = n_in;
    done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(100 + i, 0, 0, 0);
        done = 1;
      end
    join_none
    repeat (5) @(negedge clk);
    #1;
    chk("stall_accepted", 64'(n_in - base), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_sum", 64'(sum), 64'd100);
    @(posedge clk); #1;
    out_ready = 1;
    for (int n = 0; n < 100 && (!done || outs.size() < 6); n++) @(negedge clk);
    #1;
    chk("stall_count", 64'(outs.size()), 64'd6);
    for (int i = 0; i < outs.size() && i < 6; i++) chk("stall_order", 64'(outs[i]), 64'(100 + i));
    @(posedge clk); #1;

    out_ready = 0;
    send(32'h11, 32'h22, 0, 0);
    send(32'h33, 32'h44, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    base = n_out;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    repeat (6) @(negedge clk);
    #1;
    chk("midrst_no_stale", 64'(n_out - base), 64'd0);
    chk("midrst_idle", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    lit("post_rst", 32'hDEAD_0000, 32'h0000_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
